// File: rtl/block_detranspose_stream.sv
// Purpose: streams 16-word blocks out with a 4x4 transpose applied, ping-pong buffered.
// Latency: first word of a block is valid the cycle after that block's 16th input handshake.
// Backpressure: in_ready drops while both banks hold undrained blocks; output held stable under stall.
module block_detranspose_stream #(
    parameter int DW         = 32,
    parameter int FRAME_BLKS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    localparam int             FBW        = (FRAME_BLKS > 1) ? $clog2(FRAME_BLKS) : 1;
    localparam logic [FBW-1:0] FRAME_LAST = FBW'(FRAME_BLKS - 1);

    // Two 16-word banks; contents are never reset, only the full flags qualify them.
    logic [DW-1:0]  bank [2][16];
    logic [1:0]     full;
    logic [1:0]     full_nxt;

    logic           wr_bank;
    logic [3:0]     wr_cnt;
    logic           rd_bank;
    logic [3:0]     rd_cnt;
    logic [FBW-1:0] frame_blk;

    logic           wr_fire;
    logic           rd_fire;
    logic           wr_done;
    logic           rd_done;
    logic [3:0]     rd_idx;

    assign in_ready  = !rst && !full[wr_bank];
    assign out_valid = full[rd_bank];

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;
    assign wr_done = wr_fire && (wr_cnt == 4'd15);
    assign rd_done = rd_fire && (rd_cnt == 4'd15);

    // Output word r*4+c comes from stored word c*4+r: swap the two 2-bit halves of the count.
    assign rd_idx   = {rd_cnt[1:0], rd_cnt[3:2]};
    assign out_data = bank[rd_bank][rd_idx];
    assign out_last = out_valid && (rd_cnt == 4'd15) && (frame_blk == FRAME_LAST);

    // Full flags: set by the 16th write, cleared by the 16th read; the two never target one bank.
    always_comb begin
        full_nxt = full;
        if (wr_done) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    // Full flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            full <= full_nxt;
        end
    end

    // Bank storage: capture the accepted word at the current write position.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank[wr_bank][wr_cnt] <= in_data;
        end
    end

    // Write pointer: advance per accepted word, hop to the other bank after 16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_cnt  <= 4'd0;
        end else if (wr_fire) begin
            wr_cnt <= wr_cnt + 4'd1;
            if (wr_cnt == 4'd15) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Read pointer and frame position: advance per delivered word, hop bank after 16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank   <= 1'b0;
            rd_cnt    <= 4'd0;
            frame_blk <= '0;
        end else if (rd_fire) begin
            rd_cnt <= rd_cnt + 4'd1;
            if (rd_cnt == 4'd15) begin
                rd_bank <= ~rd_bank;
                if (frame_blk == FRAME_LAST) begin
                    frame_blk <= '0;
                end else begin
                    frame_blk <= frame_blk + 1'b1;
                end
            end
        end
    end

endmodule
